// File: rtl/fwft_reader.sv
// fwft_reader: turns a standard-mode FIFO (data one cycle after the read
// strobe) into a first-word-fall-through interface. A 3-entry ordered
// buffer (head, slot1, slot2) absorbs the read latency. It keeps enough
// words in flight that a consumer popping every cycle sees no bubbles.
module fwft_reader #(
    parameter int DATA_WIDTH = 36
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic [1:0]            level
);

    logic [1:0]            count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic                  empty_q, empty_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
    logic [DATA_WIDTH-1:0] slot2_q, slot2_d;

    logic                  pop;
    logic [2:0]            occupancy;
    logic [1:0]            wr_pos;

    // Flow control: a pop needs a held word. The upstream read is issued only
    // while held plus in-flight words leave room, so capture can never overflow.
    // rd_en is deliberately kept out of the read strobe to avoid a long
    // combinational path to the upstream FIFO.
    always_comb begin
        pop        = rd_en && !empty_q;
        occupancy  = {1'b0, count_q} + {2'b00, inflight_q};
        fifo_rd_en = !rst && !fifo_empty && (occupancy < 3'd3);
        wr_pos     = count_q - {1'b0, pop};
    end

    // Next buffer contents: shift on pop, then drop the returning word into
    // the first free position left after that shift.
    always_comb begin
        head_d  = head_q;
        slot1_d = slot1_q;
        slot2_d = slot2_q;
        if (pop) begin
            head_d  = slot1_q;
            slot1_d = slot2_q;
        end
        if (inflight_q) begin
            case (wr_pos)
                2'd0:    head_d  = fifo_dout;
                2'd1:    slot1_d = fifo_dout;
                default: slot2_d = fifo_dout;
            endcase
        end
        count_d    = count_q + {1'b0, inflight_q} - {1'b0, pop};
        inflight_d = fifo_rd_en;
        empty_d    = (count_d == 2'd0);
    end

    // Control state and the visible head word; reset discards any word in flight.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            empty_q    <= 1'b1;
            head_q     <= '0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            empty_q    <= empty_d;
            head_q     <= head_d;
        end
    end

    // Backing slots hold no meaning while count excludes them, so no reset.
    always_ff @(posedge rd_clk) begin
        slot1_q <= slot1_d;
        slot2_q <= slot2_d;
    end

    assign dout  = head_q;
    assign empty = empty_q;
    assign level = count_q;

endmodule

// File: tb/tb_fwft_reader.sv
// Testbench for fwft_reader: table-driven cycle vectors plus hand-written
// back-pressure, reset, streaming and random scoreboard sequences. A small
// standard-mode FIFO model feeds the DUT.
module tb_fwft_reader;

    localparam int DW = 36;

    logic          rd_clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          empty;
    logic [1:0]    level;

    int checks = 0;
    int errors = 0;

    // Upstream FIFO model
    logic [DW-1:0] up_mem [0:32767];
    int            up_wr = 0;
    int            up_rd = 0;
    logic          up_block = 1'b0;
    logic [DW-1:0] exp_q [$];

    assign fifo_empty = (up_wr == up_rd) || up_block;

    always #5 rd_clk = ~rd_clk;

    always @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            up_rd     <= up_wr;
            fifo_dout <= '0;
        end else if (fifo_rd_en) begin
            fifo_dout <= up_mem[up_rd];
            up_rd     <= up_rd + 1;
        end
    end

    fwft_reader #(.DATA_WIDTH(DW)) dut (
        .rd_clk     (rd_clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .rd_en      (rd_en),
        .dout       (dout),
        .empty      (empty),
        .level      (level)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        up_mem[up_wr] = d;
        up_wr++;
        exp_q.push_back(d);
    endtask

    task automatic sb_check(input string nm);
        logic [DW-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: popped %0h, expected no word", nm, dout);
        end else begin
            e = exp_q.pop_front();
            check(nm, 64'(dout), 64'(e));
        end
    endtask

    typedef struct {
        logic          push;
        logic [DW-1:0] data;
        logic          rd;
        logic          exp_frd;
        logic          exp_empty;
        logic [1:0]    exp_level;
        logic          chk_dout;
        logic [DW-1:0] exp_dout;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int pulses;
        int pops;
        int first_pop;
        int last_pop;
        int bubbles;
        logic [63:0] r;

        //             push  data    rd  frd emp lvl chk dout
        tbl[0] = '{1'b1, 36'h1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 36'h0};
        tbl[1] = '{1'b0, 36'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 36'h0};
        tbl[2] = '{1'b1, 36'h2, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 36'h1};
        tbl[3] = '{1'b1, 36'h3, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 36'h0};
        tbl[4] = '{1'b0, 36'h0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 36'h2};
        tbl[5] = '{1'b0, 36'h0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 36'h2};
        tbl[6] = '{1'b0, 36'h0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 36'h2};
        tbl[7] = '{1'b0, 36'h0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 36'h3};
        tbl[8] = '{1'b0, 36'h0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 36'h0};
        tbl[9] = '{1'b0, 36'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 36'h0};

        rst   = 1'b1;
        rd_en = 1'b0;
        repeat (3) @(negedge rd_clk);
        rst = 1'b0;

        // Underflow pops straight after reset
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            #1;
            check($sformatf("uf[%0d].empty", i), 64'(empty), 64'(1'b1));
            check($sformatf("uf[%0d].level", i), 64'(level), 64'(2'd0));
            check($sformatf("uf[%0d].dout", i), 64'(dout), 64'(0));
            check($sformatf("uf[%0d].fifo_rd_en", i), 64'(fifo_rd_en), 64'(1'b0));
            @(negedge rd_clk);
        end

        // Table-driven cycle vectors
        for (int i = 0; i < 10; i++) begin
            rd_en = tbl[i].rd;
            if (tbl[i].push) push(tbl[i].data);
            #1;
            check($sformatf("tbl[%0d].fifo_rd_en", i), 64'(fifo_rd_en), 64'(tbl[i].exp_frd));
            check($sformatf("tbl[%0d].empty", i), 64'(empty), 64'(tbl[i].exp_empty));
            check($sformatf("tbl[%0d].level", i), 64'(level), 64'(tbl[i].exp_level));
            if (tbl[i].chk_dout)
                check($sformatf("tbl[%0d].dout", i), 64'(dout), 64'(tbl[i].exp_dout));
            @(negedge rd_clk);
        end

        // Back-pressure: five words upstream, consumer idle
        rd_en = 1'b0;
        for (int k = 1; k <= 5; k++) push(36'h0A0000000 + DW'(k));
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (fifo_rd_en) pulses++;
            @(negedge rd_clk);
        end
        #1;
        check("bp.pulses", 64'(pulses), 64'(3));
        check("bp.level", 64'(level), 64'(2'd3));
        check("bp.empty", 64'(empty), 64'(1'b0));
        check("bp.head", 64'(dout), 64'(36'h0A0000001));
        check("bp.full_no_rd", 64'(fifo_rd_en), 64'(1'b0));
        @(negedge rd_clk);
        for (int k = 1; k <= 5; k++) begin
            rd_en = 1'b1;
            #1;
            check($sformatf("bp.word%0d.empty", k), 64'(empty), 64'(1'b0));
            check($sformatf("bp.word%0d.dout", k), 64'(dout), 64'(36'h0A0000000 + DW'(k)));
            @(negedge rd_clk);
        end
        rd_en = 1'b0;
        #1;
        check("bp.drained.empty", 64'(empty), 64'(1'b1));
        check("bp.drained.level", 64'(level), 64'(2'd0));
        @(negedge rd_clk);

        // Reset mid-burst with two words held and one in flight
        for (int k = 1; k <= 5; k++) push(36'h0B0000000 + DW'(k));
        repeat (3) @(negedge rd_clk);
        #1;
        check("rst.pre.level", 64'(level), 64'(2'd2));
        check("rst.pre.fifo_rd_en", 64'(fifo_rd_en), 64'(1'b0));
        rst = 1'b1;
        #1;
        check("rst.empty", 64'(empty), 64'(1'b1));
        check("rst.level", 64'(level), 64'(2'd0));
        check("rst.dout", 64'(dout), 64'(0));
        check("rst.fifo_rd_en", 64'(fifo_rd_en), 64'(1'b0));
        push(36'h0DEAD);
        #1;
        check("rst.gate_rd_en", 64'(fifo_rd_en), 64'(1'b0));
        @(negedge rd_clk);
        rst = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("rst.after[%0d].empty", c), 64'(empty), 64'(1'b1));
            check($sformatf("rst.after[%0d].level", c), 64'(level), 64'(2'd0));
            @(negedge rd_clk);
        end

        // Streaming: 64 words with the consumer always ready
        rd_en = 1'b1;
        for (int k = 0; k < 64; k++) push(36'h500000000 + DW'(k));
        pops = 0;
        first_pop = -1;
        last_pop = -1;
        bubbles = 0;
        for (int c = 0; c < 72; c++) begin
            #1;
            if (!empty) begin
                sb_check($sformatf("stream.word%0d", pops));
                if (first_pop < 0) first_pop = c;
                last_pop = c;
                pops++;
            end else if (pops > 0 && pops < 64) begin
                bubbles++;
            end
            @(negedge rd_clk);
        end
        check("stream.pops", 64'(pops), 64'(64));
        check("stream.first_pop_cycle", 64'(first_pop), 64'(2));
        check("stream.last_pop_cycle", 64'(last_pop), 64'(65));
        check("stream.bubbles", 64'(bubbles), 64'(0));

        // Random stalls on both sides against the scoreboard
        for (int c = 0; c < 10000; c++) begin
            rd_en    = 1'($urandom_range(0, 1));
            up_block = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                r = {$urandom(), $urandom()};
                push(r[DW-1:0]);
            end
            #1;
            check("rand.no_overread", 64'(fifo_rd_en && fifo_empty), 64'(1'b0));
            if (rd_en && !empty) sb_check("rand.pop");
            @(negedge rd_clk);
        end

        // Drain whatever is left
        up_block = 1'b0;
        rd_en    = 1'b1;
        for (int c = 0; c < 20000 && exp_q.size() > 0; c++) begin
            #1;
            if (!empty) sb_check("drain.pop");
            @(negedge rd_clk);
        end
        #1;
        check("drain.left", 64'(exp_q.size()), 64'(0));
        check("drain.empty", 64'(empty), 64'(1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
